uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver (and by a future transmitter).
// Holds the default bit timing for 115200 baud, the data width and the FSM
// state type.
package uart_pkg;

  // Clock cycles per serial bit.
  localparam int unsigned CLOCKS_PER_BIT = 217;
  // Cycles from start-edge detection to the start-bit mid-sample.
  localparam int unsigned SAMPLE_POINT   = 108;
  // 8N1 framing: eight data bits per frame.
  localparam int unsigned DATA_BITS      = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Ports:
//   clk_i  - destination clock
//   rst_i  - asynchronous active-high reset; both flops go to ResetValue
//   d_i    - asynchronous input
//   q_o    - synchronized output, two cycles behind d_i
module sync_2ff #(
  parameter logic ResetValue = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous active-high reset
//   RX    - serial line, idle high, asynchronous to clk
//   clear - acknowledges the held byte: zeroes the valid/error/overrun flags
//   out   - {valid, framing_error, overrun, 5'b0, last_good_byte}
module uart_rx #(
  parameter int unsigned CLOCKS_PER_BIT = uart_pkg::CLOCKS_PER_BIT,
  parameter int unsigned SAMPLE_POINT   = uart_pkg::SAMPLE_POINT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RX,
  input  logic        clear,
  output logic [15:0] out
);
  import uart_pkg::*;

  localparam int unsigned CntW    = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int unsigned BitIdxW = $clog2(DATA_BITS);

  localparam logic [CntW-1:0]    BitEnd   = CntW'(CLOCKS_PER_BIT - 1);
  // The counter starts at 0 on the detection edge, so reaching SAMPLE_POINT-1
  // puts the sample exactly SAMPLE_POINT cycles after detection.
  localparam logic [CntW-1:0]    StartEnd = CntW'(SAMPLE_POINT - 1);
  localparam logic [BitIdxW-1:0] LastBit  = BitIdxW'(DATA_BITS - 1);

  logic rx_sync;

  sync_2ff #(
    .ResetValue(1'b1)
  ) u_sync (
    .clk_i(clk),
    .rst_i(reset),
    .d_i  (RX),
    .q_o  (rx_sync)
  );

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitIdxW-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rx_prev_q, rx_prev_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 stop_good, stop_bad;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rx_prev_d = rx_sync;
    valid_d   = valid_q;
    ferr_d    = ferr_q;
    ovr_d     = ovr_q;
    stop_good = 1'b0;
    stop_bad  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Only a real high-to-low transition starts a frame.
        if (rx_prev_q && !rx_sync) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == StartEnd) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_sync ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == BitEnd) begin
          cnt_d     = '0;
          shift_d   = {rx_sync, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BitIdxW'(1);
          if (bit_idx_q == LastBit) begin
            state_d = StStop;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == BitEnd) begin
          cnt_d     = '0;
          state_d   = StIdle;
          stop_good = rx_sync;
          stop_bad  = !rx_sync;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A completing frame takes priority over clear for the flags it sets.
    if (stop_good) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ovr_d   = valid_q && !clear;
      ferr_d  = ferr_q && !clear;
    end else if (stop_bad) begin
      ferr_d  = 1'b1;
      valid_d = valid_q && !clear;
      ovr_d   = ovr_q && !clear;
    end else if (clear) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rx_prev_q <= 1'b1;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rx_prev_q <= rx_prev_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign out = {valid_q, ferr_q, ovr_q, 5'b00000, data_q};

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: every expected change of `out` is queued when
// the stimulus is issued; a monitor pops and compares each time `out` changes.
module tb_uart_rx;

  localparam int CPB = 217;
  localparam int SP  = 108;

  logic        clk = 1'b0;
  logic        reset;
  logic        RX;
  logic        clear;
  logic [15:0] out;

  uart_rx #(
    .CLOCKS_PER_BIT(CPB),
    .SAMPLE_POINT  (SP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .RX   (RX),
    .clear(clear),
    .out  (out)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [15:0] val;
    int          min_c;
    int          max_c;
    string       name;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  task automatic check_window(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: output at cycle %0d, expected within %0d..%0d", name, act, lo, hi);
  endtask

  task automatic push(input string name, input logic [15:0] val,
                      input int lo = 0, input int hi = 0);
    exp_t x;
    x.val   = val;
    x.min_c = lo;
    x.max_c = hi;
    x.name  = name;
    q.push_back(x);
  endtask

  // Monitor: any change of out must match the head of the scoreboard.
  logic        mon_en = 1'b0;
  logic [15:0] last_out;
  always @(negedge clk) begin
    if (!mon_en) begin
      last_out <= out;
    end else if (out !== last_out) begin
      last_out <= out;
      if (q.size() == 0) begin
        check("unexpected_change", {16'h0, out}, {16'h0, last_out});
      end else begin
        e = q.pop_front();
        check(e.name, {16'h0, out}, {16'h0, e.val});
        if (e.max_c > 0) check_window({e.name, "_latency"}, cycle, e.min_c, e.max_c);
      end
    end
  end

  // All drivers below are entered and left on a falling clock edge.
  task automatic send_byte(input logic [7:0] data, input logic stop_bit = 1'b1);
    RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = data[i];
      repeat (CPB) @(negedge clk);
    end
    RX = stop_bit;
    repeat (CPB) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    RX    = 1'b1;
    clear = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_out", {16'h0, out}, 32'h0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    // Framing error leaves the byte alone; the next good byte keeps the error flag.
    push("ferr_ff", 16'h4000);
    send_byte(8'hFF, 1'b0);
    idle(CPB);
    push("good_after_ferr", 16'hC07E);
    send_byte(8'h7E);
    idle(300);
    push("clear_after_7e", 16'h007E);
    pulse_clear();
    idle(50);

    // Single frame latency window measured from the start-bit edge.
    t = cycle;
    push("byte_55", 16'h8055, t + SP + 9 * CPB, t + 2066);
    send_byte(8'h55);
    idle(300);
    push("clear_after_55", 16'h0055);
    pulse_clear();
    idle(50);

    // Back-to-back with clear between; a clear in mid-frame changes nothing.
    push("byte_a3", 16'h80A3);
    push("clear_after_a3", 16'h00A3);
    push("byte_3c", 16'h803C);
    fork
      begin
        send_byte(8'hA3);
        send_byte(8'h3C);
      end
      begin
        repeat (2100) @(negedge clk);
        pulse_clear();
        repeat (1070) @(negedge clk);
        pulse_clear();
      end
    join
    idle(300);
    check("no_overrun_3c", {31'h0, out[13]}, 32'h0);
    push("clear_after_3c", 16'h003C);
    pulse_clear();
    idle(50);

    // Overrun: second byte lands while the first is still valid.
    push("byte_11", 16'h8011);
    push("overrun_22", 16'hA022);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(300);
    push("clear_after_22", 16'h0022);
    pulse_clear();
    idle(50);

    // Short low glitch is rejected at the start-bit sample.
    RX = 1'b0;
    repeat (50) @(negedge clk);
    idle(300);
    check("glitch_out", {16'h0, out}, 32'h0022);
    push("byte_5a_after_glitch", 16'h805A);
    send_byte(8'h5A);
    idle(300);

    // Reset in the middle of the data bits of 0x81.
    RX = 1'b0;
    repeat (CPB) @(negedge clk);
    RX = 1'b1;
    repeat (CPB) @(negedge clk);
    RX = 1'b0;
    repeat (100) @(negedge clk);
    push("reset_mid_frame", 16'h0000);
    RX    = 1'b1;
    reset = 1'b1;
    #1;
    check("reset_async_out", {16'h0, out}, 32'h0);
    @(negedge clk);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    idle(100);
    push("byte_81_after_reset", 16'h8081);
    send_byte(8'h81);
    idle(300);

    check("queue_drained", q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
